// File: rtl/lmem_1rp_nwp_pkg.sv
// Shared definitions for the LMEM write-FIFO/round-robin local memory.
package lmem_1rp_nwp_pkg;

  // Upper bound on the number of external write ports.
  localparam int LMEM_MAX_WP = 8;

  // Ceiling log2 for sizing pointers and indices; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  // Width of one packed FIFO entry: {address, data}.
  function automatic int entry_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/lmem_1rp_nwp_wr_fifo.sv
// Private per-port write FIFO holding {addr, data} entries until the drainer commits them.
module lmem_1rp_nwp_wr_fifo
  import lmem_1rp_nwp_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full comes straight from the stored count, so a pop in the same cycle never makes room for a push.
  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty;

  // Entry storage has no reset so it can map onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; reset throws away any queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lmem_1rp_nwp.sv
// Local memory with one registered read port and NUM_WP queued write ports drained two per cycle.
module lmem_1rp_nwp
  import lmem_1rp_nwp_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_WP      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_VALUES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WP-1:0]            we,
  input  logic [NUM_WP*DATA_WIDTH-1:0] data,
  input  logic [NUM_WP*ADDR_WIDTH-1:0] addr_w,
  input  logic [ADDR_WIDTH-1:0]        addr_a,
  output logic [DATA_WIDTH-1:0]        q_a,
  output logic [NUM_WP-1:0]            wfull,
  output logic [NUM_WP-1:0]            drop,
  output logic                         idle
);

  localparam int EW    = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int RPW   = clog2(NUM_WP);
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [NUM_WP-1:0]     empty;
  logic [NUM_WP-1:0]     req;
  logic [NUM_WP-1:0]     rot_req;
  logic [NUM_WP-1:0]     pop;
  logic [EW-1:0]         head [NUM_WP];
  logic [RPW-1:0]        rr_ptr;
  logic [RPW-1:0]        pos;
  logic [RPW-1:0]        idx_a;
  logic [RPW-1:0]        idx_b;
  logic [RPW-1:0]        next_a;
  logic [RPW-1:0]        next_b;
  logic                  grant_a;
  logic                  found_b;
  logic                  grant_b;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
  logic [DATA_WIDTH-1:0] wr_data_a;
  logic [DATA_WIDTH-1:0] wr_data_b;
  logic [DATA_WIDTH-1:0] ram [WORDS];

  // Preload images are attached by the vendor memory-initialisation flow keyed on INIT_VALUES.
  if (INIT_VALUES != 0) begin : g_init_image
  end

  for (genvar i = 0; i < NUM_WP; i++) begin : g_fifo
    lmem_1rp_nwp_wr_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (we[i]),
      .pop   (pop[i]),
      .din   ({addr_w[i*ADDR_WIDTH +: ADDR_WIDTH], data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .head  (head[i]),
      .full  (wfull[i]),
      .empty (empty[i])
    );
    assign pop[i] = (grant_a && (idx_a == RPW'(i))) || (grant_b && (idx_b == RPW'(i)));
  end

  assign req = ~empty;

  // Two-grant round-robin: rotate requests so rr_ptr sits at bit 0, then take the first two set bits.
  always_comb begin
    rot_req = '0;
    pos     = '0;
    idx_a   = '0;
    idx_b   = '0;
    grant_a = 1'b0;
    found_b = 1'b0;
    for (int k = 0; k < NUM_WP; k++) begin
      pos        = RPW'((int'(rr_ptr) + k) % NUM_WP);
      rot_req[k] = req[pos];
    end
    for (int k = 0; k < NUM_WP; k++) begin
      pos = RPW'((int'(rr_ptr) + k) % NUM_WP);
      if (rot_req[k]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          idx_a   = pos;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = pos;
        end
      end
    end
  end

  assign wr_addr_a = head[idx_a][EW-1 -: ADDR_WIDTH];
  assign wr_data_a = head[idx_a][DATA_WIDTH-1:0];
  assign wr_addr_b = head[idx_b][EW-1 -: ADDR_WIDTH];
  assign wr_data_b = head[idx_b][DATA_WIDTH-1:0];

  // B waits when it targets the same word as A, so the later-drained value lands on a later edge.
  assign grant_b = found_b && (wr_addr_b != wr_addr_a);

  assign next_a = RPW'((int'(idx_a) + 1) % NUM_WP);
  assign next_b = RPW'((int'(idx_b) + 1) % NUM_WP);

  // Round-robin pointer moves just past the last port served; it holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_b) begin
      rr_ptr <= next_b;
    end else if (grant_a) begin
      rr_ptr <= next_a;
    end
  end

  // Dual write-port RAM array; commits are suppressed in the reset cycle so queued writes are discarded.
  always_ff @(posedge clk) begin
    if (!rst && grant_a) ram[wr_addr_a] <= wr_data_a;
    if (!rst && grant_b) ram[wr_addr_b] <= wr_data_b;
  end

  // Registered read with read-old-data behaviour against a commit on the same edge.
  always_ff @(posedge clk) begin
    if (rst) q_a <= '0;
    else     q_a <= ram[addr_a];
  end

  // One-cycle drop pulse for writes offered to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) drop <= '0;
    else     drop <= we & wfull;
  end

  assign idle = (&empty) && !grant_a;

endmodule

// File: tb/tb_lmem_1rp_nwp.sv
// Self-checking bench for lmem_1rp_nwp: table-driven write bursts plus hand-written corner sequences.
module tb_lmem_1rp_nwp;

  localparam int DW  = 18;
  localparam int AW  = 8;
  localparam int NWP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NWP-1:0]    we;
  logic [NWP*DW-1:0] data;
  logic [NWP*AW-1:0] addr_w;
  logic [AW-1:0]     addr_a;
  logic [DW-1:0]     q_a;
  logic [NWP-1:0]    wfull;
  logic [NWP-1:0]    drop;
  logic              idle;

  logic [DW-1:0] wd [NWP];
  logic [AW-1:0] wa [NWP];

  typedef struct {
    logic [DW-1:0] exp;
    string         name;
  } rd_exp_t;

  typedef struct packed {
    logic [NWP-1:0]         mask;
    logic [NWP-1:0][AW-1:0] a;
    logic [NWP-1:0][DW-1:0] d;
  } burst_t;

  rd_exp_t sb_q[$];
  burst_t  tbl [3];
  int      checks   = 0;
  int      failures = 0;

  lmem_1rp_nwp #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_WP      (NWP),
    .FIFO_DEPTH  (4),
    .INIT_VALUES (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .data   (data),
    .addr_w (addr_w),
    .addr_a (addr_a),
    .q_a    (q_a),
    .wfull  (wfull),
    .drop   (drop),
    .idle   (idle)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Pack per-port write fields onto the flat DUT buses.
  always_comb begin
    data   = '0;
    addr_w = '0;
    for (int p = 0; p < NWP; p++) begin
      data[p*DW +: DW]   = wd[p];
      addr_w[p*AW +: AW] = wa[p];
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any read issued in the previous cycle.
  task automatic next_cycle();
    rd_exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.name, 32'(q_a), 32'(e.exp));
    end
  endtask

  task automatic applyStimulus(input logic [NWP-1:0] mask, input logic rd, input logic [AW-1:0] ra,
                               input logic [DW-1:0] exp, input string name);
    rd_exp_t e;
    we     = mask;
    addr_a = ra;
    if (rd) begin
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
    end
    next_cycle();
  endtask

  task automatic idle_cycle();
    applyStimulus('0, 1'b0, '0, '0, "");
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    applyStimulus('0, 1'b1, a, exp, name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 40) begin
      idle_cycle();
      n++;
    end
    checkOutput(name, 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we  = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  function automatic bit is_dropped(input int p, input int c);
    return (c >= 6) && ((p >= 2) == (c % 2 == 0));
  endfunction

  initial begin
    logic [NWP-1:0] exp_drop;

    rst    = 1'b1;
    we     = '0;
    addr_a = '0;
    for (int p = 0; p < NWP; p++) begin
      wd[p] = '0;
      wa[p] = '0;
    end

    tbl[0].mask = 4'b1111;
    tbl[0].a    = {8'h03, 8'h02, 8'h01, 8'h00};
    tbl[0].d    = {18'h3FFFF, 18'h33333, 18'h22222, 18'h00011};
    tbl[1].mask = 4'b1010;
    tbl[1].a    = {8'hFF, 8'h00, 8'h80, 8'h00};
    tbl[1].d    = {18'h15555, 18'h00000, 18'h2AAAA, 18'h00000};
    tbl[2].mask = 4'b0101;
    tbl[2].a    = {8'h00, 8'h00, 8'h00, 8'h81};
    tbl[2].d    = {18'h00000, 18'h00001, 18'h00000, 18'h1C0DE};

    // Reset state.
    next_cycle();
    next_cycle();
    rst = 1'b0;
    checkOutput("reset_q_a", 32'(q_a), 32'd0);
    checkOutput("reset_wfull", 32'(wfull), 32'd0);
    checkOutput("reset_drop", 32'(drop), 32'd0);
    checkOutput("reset_idle", 32'(idle), 32'd1);

    // Single write on port 2.
    wa[2] = 8'h10;
    wd[2] = 18'h155;
    applyStimulus(4'b0100, 1'b0, '0, '0, "");
    checkOutput("single_queued_idle", 32'(idle), 32'd0);
    wait_idle("single_idle");
    do_read(8'h10, 18'h155, "single_read");

    // Table-driven write bursts followed by read-back.
    for (int v = 0; v < 3; v++) begin
      for (int p = 0; p < NWP; p++) begin
        wa[p] = tbl[v].a[p];
        wd[p] = tbl[v].d[p];
      end
      applyStimulus(tbl[v].mask, 1'b0, '0, '0, "");
      if (v == 0) begin
        checkOutput("burst0_idle_c1", 32'(idle), 32'd0);
        idle_cycle();
        checkOutput("burst0_idle_c2", 32'(idle), 32'd0);
        idle_cycle();
        checkOutput("burst0_idle_c3", 32'(idle), 32'd1);
      end else begin
        wait_idle($sformatf("burst%0d_idle", v));
      end
      for (int p = 0; p < NWP; p++) begin
        if (tbl[v].mask[p]) do_read(tbl[v].a[p], tbl[v].d[p], $sformatf("burst%0d_read_p%0d", v, p));
      end
    end

    // Same-address collision with rr_ptr at 0: port 0 commits first, port 1 one cycle later.
    do_reset();
    wa[0] = 8'h20;
    wd[0] = 18'h0AA;
    wa[1] = 8'h20;
    wd[1] = 18'h0BB;
    applyStimulus(4'b0011, 1'b0, '0, '0, "");
    idle_cycle();
    checkOutput("collide_b_pending", 32'(idle), 32'd0);
    do_read(8'h20, 18'h0AA, "collide_first");
    do_read(8'h20, 18'h0BB, "collide_final");
    checkOutput("collide_idle", 32'(idle), 32'd1);

    // Overflow: every port writes every cycle, drain keeps up with only two.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < NWP; p++) begin
        wa[p] = AW'(144 + p * 16 + c);
        wd[p] = DW'((p << 12) | (c << 4) | 5);
      end
      applyStimulus(4'b1111, 1'b0, '0, '0, "");
      exp_drop = '0;
      for (int p = 0; p < NWP; p++) exp_drop[p] = is_dropped(p, c);
      checkOutput($sformatf("ovf_drop_c%0d", c), 32'(drop), 32'(exp_drop));
      if (c == 5) checkOutput("ovf_wfull_c5", 32'(wfull), 32'(4'b1100));
    end
    idle_cycle();
    checkOutput("ovf_drop_clears", 32'(drop), 32'd0);
    wait_idle("ovf_idle");
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < NWP; p++) begin
        if (!is_dropped(p, c))
          do_read(AW'(144 + p * 16 + c), DW'((p << 12) | (c << 4) | 5), $sformatf("ovf_read_p%0d_c%0d", p, c));
      end
    end

    // Reset mid-operation: queued writes vanish and the RAM keeps its earlier contents.
    for (int p = 0; p < NWP; p++) begin
      wa[p] = AW'(8'h30 + p);
      wd[p] = DW'(18'h300 + p);
    end
    applyStimulus(4'b1111, 1'b0, '0, '0, "");
    wa[0] = 8'h34;
    wd[0] = 18'h304;
    applyStimulus(4'b0001, 1'b0, '0, '0, "");
    wait_idle("rstmid_prefill_idle");
    do_read(8'h31, 18'h301, "rstmid_prefill_read");
    for (int p = 0; p < NWP; p++) begin
      wa[p] = AW'(8'h30 + p);
      wd[p] = DW'(18'h3F000 + p);
    end
    applyStimulus(4'b1111, 1'b0, '0, '0, "");
    rst   = 1'b1;
    wa[1] = 8'h34;
    wd[1] = 18'h3ABCD;
    applyStimulus(4'b0010, 1'b0, '0, '0, "");
    rst = 1'b0;
    checkOutput("rstmid_idle", 32'(idle), 32'd1);
    checkOutput("rstmid_wfull", 32'(wfull), 32'd0);
    checkOutput("rstmid_drop", 32'(drop), 32'd0);
    checkOutput("rstmid_q_a", 32'(q_a), 32'd0);
    idle_cycle();
    for (int k = 0; k < 5; k++) do_read(AW'(8'h30 + k), DW'(18'h300 + k), $sformatf("rstmid_keep_%0d", k));

    // Read-old-data against a commit on the same edge.
    wa[0] = 8'h40;
    wd[0] = 18'h001;
    applyStimulus(4'b0001, 1'b0, '0, '0, "");
    wait_idle("rod_first_idle");
    wd[0] = 18'h002;
    applyStimulus(4'b0001, 1'b0, '0, '0, "");
    do_read(8'h40, 18'h001, "rod_old");
    do_read(8'h40, 18'h002, "rod_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
